// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and memory-stage types used by mem_stage and mem_align.
package rv32_pkg;

    localparam logic [6:0] LOAD_OP   = 7'b0000011;
    localparam logic [6:0] STORE_OP  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM_OP = 7'b0010011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_e;

    // Everything about an in-flight access that the writeback register needs later.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] alu;
        logic [4:0]  wbReg;
        logic        wbEn;
        logic        isLoad;
    } mem_req_t;

    function automatic logic isLoadF3(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic isStoreF3(input logic [2:0] f3);
        return (f3 == SB) || (f3 == SH) || (f3 == SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the memory stage (master) and memory (slave).
interface mem_stage_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_we, d_addr, d_be, d_wdata,
        input  d_ack, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_be, d_wdata,
        output d_ack, d_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension.
module mem_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [1:0]  lane;
    logic [15:0] shifted;

    always_comb begin
        lane        = 2'b00;
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;

        // Low address bits below the access size are dropped, giving natural alignment.
        case (funct3_i[1:0])
            2'b00: begin
                lane    = addr_lo_i;
                be_o    = 4'b0001 << lane;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                lane    = {addr_lo_i[1], 1'b0};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                lane    = 2'b00;
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase

        shifted = 16'(rdata_i >> {lane, 3'b000});

        case (funct3_i)
            LB:      load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_data_o = {24'h000000, shifted[7:0]};
            LHU:     load_data_o = {16'h0000, shifted[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: req/ack loads/stores, writeback register and MEM forwarding tuple.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of truncating.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        w_en_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_en_in,
    output logic        stall_out,
    mem_stage_if.master dmem,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_en_out,
    output logic        bus_err_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    mem_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    mem_req_t    cap_q, cap_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] iw_q, iw_d;
    logic [31:0] wbData_q, wbData_d;
    logic [4:0]  wbReg_q, wbReg_d;
    logic        wbEn_q, wbEn_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        isLoad, isStore, memOpcode, memOp, trap;
    logic [2:0]  alignF3;
    logic [1:0]  alignLo;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata, loadData;

    assign opcode    = iw_in[6:0];
    assign funct3    = iw_in[14:12];
    assign isLoad    = (opcode == LOAD_OP) && isLoadF3(funct3);
    assign isStore   = (opcode == STORE_OP) && w_en_in && isStoreF3(funct3);
    assign memOpcode = (opcode == LOAD_OP) || (opcode == STORE_OP);
    assign memOp     = isLoad || isStore;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memOp && (((funct3[1:0] == 2'b01) && alu_in[0]) ||
                            ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // One aligner serves both the request capture (IDLE) and the load return (ACCESS).
    assign alignF3 = (state_q == ACCESS) ? cap_q.iw[14:12] : funct3;
    assign alignLo = (state_q == ACCESS) ? cap_q.alu[1:0]  : alu_in[1:0];

    mem_align u_align (
        .funct3_i     (alignF3),
        .addr_lo_i    (alignLo),
        .store_data_i (rs2_data_in),
        .rdata_i      (dmem.d_rdata),
        .be_o         (alignBe),
        .wdata_o      (alignWdata),
        .load_data_o  (loadData)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        iw_d      = iw_q;
        wbData_d  = wbData_q;
        wbReg_d   = wbReg_q;
        wbEn_d    = wbEn_q;
        err_d     = 1'b0;
        stall_out = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (valid_in) begin
                    if (trap) begin
                        valid_d  = 1'b1;
                        pc_d     = pc_in;
                        iw_d     = iw_in;
                        wbData_d = alu_in;
                        wbReg_d  = wb_reg_in;
                        wbEn_d   = 1'b0;
                        err_d    = 1'b1;
                    end else if (memOp) begin
                        stall_out = 1'b1;
                        state_d   = ACCESS;
                        req_d     = 1'b1;
                        we_d      = isStore;
                        addr_d    = {alu_in[31:2], 2'b00};
                        be_d      = alignBe;
                        wdata_d   = alignWdata;
                        cnt_d     = 8'd0;
                        cap_d     = '{pc: pc_in, iw: iw_in, alu: alu_in, wbReg: wb_reg_in,
                                      wbEn: wb_en_in, isLoad: isLoad};
                    end else begin
                        valid_d  = 1'b1;
                        pc_d     = pc_in;
                        iw_d     = iw_in;
                        wbData_d = alu_in;
                        wbReg_d  = wb_reg_in;
                        wbEn_d   = wb_en_in && !memOpcode;
                    end
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                valid_d   = 1'b0;
                // An ack arriving on the expiry cycle still completes the access normally.
                if (dmem.d_ack || (cnt_q == TIMEOUT_LAST)) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    valid_d  = 1'b1;
                    pc_d     = cap_q.pc;
                    iw_d     = cap_q.iw;
                    wbReg_d  = cap_q.wbReg;
                    wbData_d = (dmem.d_ack && cap_q.isLoad) ? loadData : cap_q.alu;
                    wbEn_d   = dmem.d_ack && cap_q.isLoad && cap_q.wbEn;
                    err_d    = !dmem.d_ack;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            cap_q    <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            iw_q     <= '0;
            wbData_q <= '0;
            wbReg_q  <= '0;
            wbEn_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            iw_q     <= iw_d;
            wbData_q <= wbData_d;
            wbReg_q  <= wbReg_d;
            wbEn_q   <= wbEn_d;
            err_q    <= err_d;
        end
    end

    assign dmem.d_req    = req_q;
    assign dmem.d_we     = we_q;
    assign dmem.d_addr   = addr_q;
    assign dmem.d_be     = be_q;
    assign dmem.d_wdata  = wdata_q;

    assign valid_out     = valid_q;
    assign pc_out        = pc_q;
    assign iw_out        = iw_q;
    assign wb_data_out   = wbData_q;
    assign wb_reg_out    = wbReg_q;
    assign wb_en_out     = wbEn_q;
    assign bus_err_out   = err_q;

    assign df_mem_enable = valid_q && wbEn_q && (wbReg_q != 5'd0);
    assign df_mem_reg    = wbReg_q;
    assign df_mem_data   = wbData_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected WB and bus events; monitors compare.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic        w_en_in;
    logic [4:0]  wb_reg_in;
    logic        wb_en_in;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] pc_out, iw_out, wb_data_out;
    logic [4:0]  wb_reg_out;
    logic        wb_en_out, bus_err_out;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    mem_stage_if dmem();

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] data;
        logic        dataCare;
        logic [4:0]  rd;
        logic        en;
        logic        err;
    } wbExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wdataCare;
    } busExp_t;

    wbExp_t  wbQ[$];
    busExp_t busQ[$];
    int      errors = 0;
    int      checks = 0;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .pc_in         (pc_in),
        .iw_in         (iw_in),
        .alu_in        (alu_in),
        .rs2_data_in   (rs2_data_in),
        .w_en_in       (w_en_in),
        .wb_reg_in     (wb_reg_in),
        .wb_en_in      (wb_en_in),
        .stall_out     (stall_out),
        .dmem          (dmem),
        .valid_out     (valid_out),
        .pc_out        (pc_out),
        .iw_out        (iw_out),
        .wb_data_out   (wb_data_out),
        .wb_reg_out    (wb_reg_out),
        .wb_en_out     (wb_en_out),
        .bus_err_out   (bus_err_out),
        .df_mem_enable (df_mem_enable),
        .df_mem_reg    (df_mem_reg),
        .df_mem_data   (df_mem_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic pushWb(input logic [31:0] pc, iw, data, input logic care,
                          input logic [4:0] rd, input logic en, input logic err);
        wbExp_t e;
        e = '{pc: pc, iw: iw, data: data, dataCare: care, rd: rd, en: en, err: err};
        wbQ.push_back(e);
    endtask

    task automatic pushBus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic care);
        busExp_t b;
        b = '{we: we, addr: addr, be: be, wdata: wdata, wdataCare: care};
        busQ.push_back(b);
    endtask

    // Presents one instruction, answers the memory port on access cycle ackCycle (0 = never).
    task automatic applyStimulus(input string name, input logic [31:0] pc, iw, alu, rs2,
                                 input logic wEn, input logic [4:0] rd, input logic wbEn,
                                 input logic isMem, input int ackCycle, input logic [31:0] rdata,
                                 input int expStall, input int expReq);
        int stalls = 0;
        int reqs = 0;
        logic done = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
        w_en_in = wEn; wb_reg_in = rd; wb_en_in = wbEn;
        #1;
        stalls += int'(stall_out);
        if (isMem) begin
            for (int k = 1; k <= 64; k++) begin
                @(negedge clk);
                dmem.d_ack = 1'b0;
                if (!dmem.d_req) begin
                    done = 1'b1;
                    break;
                end
                if (k == ackCycle) begin
                    dmem.d_ack = 1'b1;
                    dmem.d_rdata = rdata;
                end
                if (k == 1) checkOutput({name, "/dfInAccess"}, 32'(df_mem_enable), 32'd0);
                #1;
                stalls += int'(stall_out);
                reqs++;
            end
            checkOutput({name, "/accessEnded"}, 32'(done), 32'd1);
            checkOutput({name, "/reqCycles"}, 32'(reqs), 32'(expReq));
        end else begin
            @(negedge clk);
        end
        valid_in = 1'b0; w_en_in = 1'b0; wb_en_in = 1'b0;
        checkOutput({name, "/stallCycles"}, 32'(stalls), 32'(expStall));
    endtask

    // WB and bus monitors: pop the oldest expectation whenever the DUT presents an event.
    initial begin
        logic reqSeen = 1'b0;
        wbExp_t e;
        busExp_t b;
        forever begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                if (wbQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(valid_out), 32'd0);
                end else begin
                    e = wbQ.pop_front();
                    checkOutput("wbPc", pc_out, e.pc);
                    checkOutput("wbIw", iw_out, e.iw);
                    checkOutput("wbReg", 32'(wb_reg_out), 32'(e.rd));
                    checkOutput("wbEn", 32'(wb_en_out), 32'(e.en));
                    checkOutput("busErr", 32'(bus_err_out), 32'(e.err));
                    checkOutput("dfEnable", 32'(df_mem_enable), 32'(e.en && (e.rd != 5'd0)));
                    checkOutput("dfReg", 32'(df_mem_reg), 32'(e.rd));
                    if (e.dataCare) begin
                        checkOutput("wbData", wb_data_out, e.data);
                        checkOutput("dfData", df_mem_data, e.data);
                    end
                end
            end else if (bus_err_out) begin
                checkOutput("strayBusErr", 32'(bus_err_out), 32'd0);
            end
            if (dmem.d_req && !reqSeen) begin
                if (busQ.size() == 0) begin
                    checkOutput("unexpectedReq", 32'(dmem.d_req), 32'd0);
                end else begin
                    b = busQ.pop_front();
                    checkOutput("busWe", 32'(dmem.d_we), 32'(b.we));
                    checkOutput("busAddr", dmem.d_addr, b.addr);
                    checkOutput("busBe", 32'(dmem.d_be), 32'(b.be));
                    if (b.wdataCare) checkOutput("busWdata", dmem.d_wdata, b.wdata);
                end
            end
            reqSeen = dmem.d_req;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; valid_in = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0;
        w_en_in = 1'b0; wb_reg_in = '0; wb_en_in = 1'b0;
        dmem.d_ack = 1'b0; dmem.d_rdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstValid", 32'(valid_out), 32'd0);
        checkOutput("rstReq", 32'(dmem.d_req), 32'd0);
        checkOutput("rstStall", 32'(stall_out), 32'd0);
        checkOutput("rstWbData", wb_data_out, 32'd0);
        checkOutput("rstDf", 32'(df_mem_enable), 32'd0);
        checkOutput("rstErr", 32'(bus_err_out), 32'd0);
        reset = 1'b0;

        // ADD x5 = 0x1234
        pushWb(32'h1000, 32'h000002B3, 32'h00001234, 1'b1, 5'd5, 1'b1, 1'b0);
        applyStimulus("add", 32'h1000, 32'h000002B3, 32'h00001234, 32'h0, 1'b0, 5'd5, 1'b1,
                      1'b0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("validClears", 32'(valid_out), 32'd0);

        // SB at 0x103, ack on third access cycle
        pushBus(1'b1, 32'h00000100, 4'b1000, 32'hDDDDDDDD, 1'b1);
        pushWb(32'h1004, 32'h00000023, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus("sb", 32'h1004, 32'h00000023, 32'h00000103, 32'hAABBCCDD, 1'b1, 5'd0, 1'b0,
                      1'b1, 3, 32'h0, 4, 3);

        // LB / LBU at 0x202
        pushBus(1'b0, 32'h00000200, 4'b0100, 32'h0, 1'b0);
        pushWb(32'h1008, 32'h00000303, 32'hFFFFFF80, 1'b1, 5'd6, 1'b1, 1'b0);
        applyStimulus("lb", 32'h1008, 32'h00000303, 32'h00000202, 32'h0, 1'b0, 5'd6, 1'b1,
                      1'b1, 1, 32'h00800000, 2, 1);
        pushBus(1'b0, 32'h00000200, 4'b0100, 32'h0, 1'b0);
        pushWb(32'h100C, 32'h00004303, 32'h00000080, 1'b1, 5'd6, 1'b1, 1'b0);
        applyStimulus("lbu", 32'h100C, 32'h00004303, 32'h00000202, 32'h0, 1'b0, 5'd6, 1'b1,
                      1'b1, 1, 32'h00800000, 2, 1);

        // LW timeout, then LW acked on the expiry cycle
        pushBus(1'b0, 32'h00000400, 4'b1111, 32'h0, 1'b0);
        pushWb(32'h1010, 32'h00002383, 32'h0, 1'b0, 5'd7, 1'b0, 1'b1);
        applyStimulus("lwTimeout", 32'h1010, 32'h00002383, 32'h00000400, 32'h0, 1'b0, 5'd7, 1'b1,
                      1'b1, 0, 32'h0, 5, 4);
        pushBus(1'b0, 32'h00000404, 4'b1111, 32'h0, 1'b0);
        pushWb(32'h1014, 32'h00002383, 32'h12345678, 1'b1, 5'd7, 1'b1, 1'b0);
        applyStimulus("lwAckAtExpiry", 32'h1014, 32'h00002383, 32'h00000404, 32'h0, 1'b0, 5'd7, 1'b1,
                      1'b1, 4, 32'h12345678, 5, 4);

        // Load opcode with unsupported funct3 behaves as non-memory, no writeback
        pushWb(32'h1018, 32'h00003403, 32'h00000055, 1'b1, 5'd8, 1'b0, 1'b0);
        applyStimulus("badF3", 32'h1018, 32'h00003403, 32'h00000055, 32'h0, 1'b0, 5'd8, 1'b1,
                      1'b0, 0, 32'h0, 0, 0);

        // LH at 0x301
`ifdef MEM_MISALIGN_TRAP_EN
        pushWb(32'h101C, 32'h00001483, 32'h0, 1'b0, 5'd9, 1'b0, 1'b1);
        applyStimulus("lhMisalign", 32'h101C, 32'h00001483, 32'h00000301, 32'h0, 1'b0, 5'd9, 1'b1,
                      1'b0, 0, 32'h0, 0, 0);
`else
        pushBus(1'b0, 32'h00000300, 4'b0011, 32'h0, 1'b0);
        pushWb(32'h101C, 32'h00001483, 32'hFFFFF00D, 1'b1, 5'd9, 1'b1, 1'b0);
        applyStimulus("lhMisalign", 32'h101C, 32'h00001483, 32'h00000301, 32'h0, 1'b0, 5'd9, 1'b1,
                      1'b1, 1, 32'h0000F00D, 2, 1);
`endif

        // SH upper half, LHU upper half, SW, ADD to x0
        pushBus(1'b1, 32'h00000100, 4'b1100, 32'hABCDABCD, 1'b1);
        pushWb(32'h1020, 32'h00001023, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus("sh", 32'h1020, 32'h00001023, 32'h00000102, 32'h1234ABCD, 1'b1, 5'd0, 1'b0,
                      1'b1, 2, 32'h0, 3, 2);
        pushBus(1'b0, 32'h00000204, 4'b1100, 32'h0, 1'b0);
        pushWb(32'h1024, 32'h00005583, 32'h00008001, 1'b1, 5'd11, 1'b1, 1'b0);
        applyStimulus("lhu", 32'h1024, 32'h00005583, 32'h00000206, 32'h0, 1'b0, 5'd11, 1'b1,
                      1'b1, 1, 32'h80010000, 2, 1);
        pushBus(1'b1, 32'h00000108, 4'b1111, 32'hCAFEBABE, 1'b1);
        pushWb(32'h1028, 32'h00002023, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus("sw", 32'h1028, 32'h00002023, 32'h00000108, 32'hCAFEBABE, 1'b1, 5'd0, 1'b0,
                      1'b1, 1, 32'h0, 2, 1);
        pushWb(32'h102C, 32'h00000033, 32'h00000099, 1'b1, 5'd0, 1'b1, 1'b0);
        applyStimulus("addX0", 32'h102C, 32'h00000033, 32'h00000099, 32'h0, 1'b0, 5'd0, 1'b1,
                      1'b0, 0, 32'h0, 0, 0);

        // Reset during the second access cycle; a late ack must be ignored
        pushBus(1'b0, 32'h00000500, 4'b1111, 32'h0, 1'b0);
        @(negedge clk);
        valid_in = 1'b1; pc_in = 32'h1030; iw_in = 32'h00002503; alu_in = 32'h00000500;
        wb_reg_in = 5'd10; wb_en_in = 1'b1;
        @(negedge clk);
        checkOutput("rstMidAcc1Req", 32'(dmem.d_req), 32'd1);
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; wb_en_in = 1'b0;
        @(negedge clk);
        checkOutput("rstMidReq", 32'(dmem.d_req), 32'd0);
        checkOutput("rstMidValid", 32'(valid_out), 32'd0);
        checkOutput("rstMidStall", 32'(stall_out), 32'd0);
        checkOutput("rstMidBe", 32'(dmem.d_be), 32'd0);
        checkOutput("rstMidAddr", dmem.d_addr, 32'd0);
        reset = 1'b0;
        dmem.d_ack = 1'b1; dmem.d_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dmem.d_ack = 1'b0;
        checkOutput("lateAckValid", 32'(valid_out), 32'd0);
        @(negedge clk);
        checkOutput("lateAckValid2", 32'(valid_out), 32'd0);
        checkOutput("lateAckReq", 32'(dmem.d_req), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("wbQueueEmpty", 32'(wbQ.size()), 32'd0);
        checkOutput("busQueueEmpty", 32'(busQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It sits directly downstream of the execute/ALU stage and consumes that stage's ALU result, store data, write-enable and writeback tag.
- Performs RV32I loads and stores over a req/ack data-memory port and registers results toward writeback.
- Publishes its own MEM-stage forwarding tuple (df_mem_*) back to decode.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 255, max cycles waiting for d_ack before abort; 8-bit counter, legal range 1..255.
- LOAD_OP, 7'b0000011, load opcode.
- STORE_OP, 7'b0100011, store opcode.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  execute stage presents an instruction
- pc_in  in  32  instruction PC
- iw_in  in  32  instruction word (funct3 = iw_in[14:12], opcode = iw_in[6:0])
- alu_in  in  32  ALU result; this is the effective address for memory ops
- rs2_data_in  in  32  store data
- w_en_in  in  1  store request from execute stage
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  register writeback enable
- stall_out  out  1  upstream must hold all inputs stable
- d_req  out  1  memory request, held until ack or abort
- d_we  out  1  write (store)
- d_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- d_be  out  4  byte enables
- d_wdata  out  32  lane-replicated store data
- d_ack  in  1  access complete
- d_rdata  in  32  read word, valid with d_ack
- valid_out  out  1  WB register holds an instruction
- pc_out, iw_out  out  32  passed through
- wb_data_out  out  32  load data or alu_in
- wb_reg_out  out  5  passed through
- wb_en_out  out  1  writeback enable
- bus_err_out  out  1  one-cycle pulse: timeout or misalign trap
- df_mem_enable  out  1  forwarding valid
- df_mem_reg  out  5  forwarded register
- df_mem_data  out  32  forwarded data

Behaviour:
- Reset: all outputs 0, FSM=IDLE, timeout counter=0. If reset is asserted mid-access, d_req drops at that same edge and any late d_ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, valid_in=1, non-memory op: next edge loads the WB register (wb_data_out=alu_in, valid_out=1). Latency is 1 cycle and stall_out stays 0.
- IDLE, valid_in=1, load/store: next edge enters ACCESS and registers d_req=1, d_we, d_addr, d_be and d_wdata from the captured request.
  - stall_out=1 combinationally from that same cycle (the capture cycle) through the ACK cycle.
  - valid_out=0 while in ACCESS.
- Byte enables / store data:
  - SB: d_be = 1<<addr[1:0]; d_wdata = {4{rs2[7:0]}}.
  - SH: d_be = 4'b0011 or 4'b1100 by addr[1]; d_wdata = {2{rs2[15:0]}}.
  - SW: d_be = 4'b1111.
  - Loads: d_be as for the same access size; d_we=0.
- ACCESS + d_ack: d_req drops at the next edge and the FSM returns to IDLE. The WB register loads with valid_out=1.
  - Load: wb_data_out = lane selected by addr[1:0].
    - LB / LH: sign-extended.
    - LBU / LHU: zero-extended.
    - LW: full word.
  - Store: wb_en_out=0.
- ACCESS, no ack: counter increments each cycle. When counter == ACK_TIMEOUT-1 without ack:
  - abort: d_req drops, bus_err_out pulses, valid_out=1 with wb_en_out=0;
  - return to IDLE.
  - d_ack in the same cycle as expiry: the ack wins.
- Unsupported funct3 on LOAD_OP/STORE_OP: treated as a non-memory op with wb_en_out forced to 0.
- Forwarding: df_mem_enable = valid_out & wb_en_out & (wb_reg_out != 0); df_mem_reg = wb_reg_out; df_mem_data = wb_data_out.
  - df_mem_enable is never asserted during ACCESS.
- When valid_in=0 in IDLE, valid_out clears at the next edge.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request.
  - Next edge: valid_out=1, wb_en_out=0, bus_err_out pulses.
- Undefined: low address bits are truncated to natural alignment (halfword: addr[0] cleared; word: addr[1:0] cleared) and the access proceeds normally. bus_err_out only ever reports timeout.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants LOAD_OP/STORE_OP, and the ADD_SUB opcode constants shared with the ALU;
  - funct3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW;
  - FSM state typedef.
- One natural sub-module: mem_align. It is combinational and covers lane/byte-enable generation plus load extraction and extension.

Test Plan:
- ADD result 0x0000_1234 to x5 with wb_en=1 -> next cycle valid_out=1, wb_data_out=0x1234, df_mem_enable=1, df_mem_reg=5, stall_out never asserted.
- SB at addr 0x103, rs2=0xAABBCCDD -> d_be=4'b1000, d_addr=0x100, d_wdata=0xDDDDDDDD. Ack after 3 cycles -> wb_en_out=0, stall_out high for 4 cycles.
- LB at 0x202, d_rdata=0x0080_0000 -> wb_data_out=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LW with no ack, ACK_TIMEOUT=4 -> d_req drops after 4 cycles, bus_err_out pulse, wb_en_out=0. Repeat with the ack arriving on the expiry cycle -> normal completion, no error.
- reset asserted in the 2nd ACCESS cycle -> d_req=0 at that edge, all outputs 0; an ack one cycle later produces no valid_out.
- LH at 0x301:
  - with MEM_MISALIGN_TRAP_EN -> no d_req, bus_err_out pulse.
  - without it -> d_addr=0x300, d_be=4'b0011.
